uart_rx_top: RTL and testbench
==============================

Name: uart_rx_top

Overview:
16550-style UART receiver; the receive-side counterpart of the existing uart_tx_top, sharing its baud_pulse (16x oversample) and line-control fields. It detects the start bit, samples each bit at mid-period, and checks parity, stop-bit framing and break. It then pushes one character plus status flags per frame toward the RX FIFO. Sits between the pad-side serial input and the RX FIFO/LSR logic.

Parameters:
OVERSAMPLE, 16, baud_pulse ticks per bit; must be a power of 2, at least 8.
MID_SAMPLE, OVERSAMPLE/2-1 (=7), ticks after start-edge detection at which the start bit is re-checked.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
baud_pulse  in  1  single-cycle 16x oversample tick
rx  in  1  serial input, idle high
sticky_parity  in  1  LCR stick parity
eps  in  1  LCR even parity select
pen  in  1  LCR parity enable
wls  in  2  LCR word length: 00=5, 01=6, 10=7, 11=8 bits
push  out  1  one-clk pulse: dout/pe/fe/bi valid
dout  out  8  received character, LSB first on line, right-justified, unused upper bits 0
pe  out  1  parity error for the pushed character
fe  out  1  framing error (stop bit sampled 0)
bi  out  1  break indication
rx_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; push=0, dout=8'h00, pe=fe=bi=0; counters cleared. Reset mid-frame aborts the frame with no push.
- All state/counter updates occur only on clk edges where baud_pulse=1; push is the only output that pulses, 1 clk wide.
- Frame config (wls, pen, eps, sticky_parity) is latched on start detection; changes mid-frame have no effect until the next frame.
- States (uart_rx_state_t): IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE: rx=0 on a baud_pulse -> START, cnt<=MID_SAMPLE, latch config, clear data/index.
- START: cnt!=0 -> decrement. cnt=0 and rx=0 -> DATA, cnt<=OVERSAMPLE-1. cnt=0 and rx=1 -> false start, IDLE, no push.
- DATA: cnt!=0 -> decrement. cnt=0 -> data[idx]<=rx, cnt<=OVERSAMPLE-1. After bit N-1 (N=5+wls): -> PARITY if pen, else STOP.
- PARITY: at cnt=0, sample rx into par_bit, cnt<=OVERSAMPLE-1, -> STOP.
- Expected parity over the N data bits, keyed on {sticky_parity,eps}, identical to the TX mapping: 00 odd, so expected = ~^data; 01 even, so expected = ^data; 10 expected = 1; 11 expected = 0.
- pe = pen & (par_bit != expected). pe=0 when pen=0.
- STOP: at cnt=0, sample the stop bit, and in that same clk register dout<=data, pe, fe=~rx, and bi = (data==0) & (~pen | par_bit==0) & (rx==0). push=1 for that clk only.
- STOP exit: rx=1 -> IDLE; rx=0 -> BREAK_WAIT.
- Only the first stop bit is checked; stb is not an input.
- BREAK_WAIT: stay until rx=1 sampled on a baud_pulse, then IDLE. No new start is detected while rx is held low.
- dout/pe/fe/bi hold their value until the next push.
- Latency: push occurs at the mid-sample of the stop bit, i.e. (MID_SAMPLE+1) + OVERSAMPLE*(N+pen+1) baud_pulses after the first low sample.
- Baud_pulse gaps of any length simply stall the FSM.

Optional Feature:
UART_RX_SYNC_EN:
- Defined: rx passes through a 2-flop synchronizer (reset to 1) before the FSM; all sampling is delayed 2 clk.
- Undefined: rx is used directly; the caller guarantees rx is synchronous to clk.
- Functional results are identical either way when rx is stable around the baud_pulse.

Decomposition:
- Package uart_pkg: uart_rx_state_t enum, OVERSAMPLE/MID_SAMPLE defaults, wls decode constants, a parity-mode function shared with the TX, and the TX state localparams moved in.
- One sub-module, uart_rx_sync: the 2-flop synchronizer, instantiated only under UART_RX_SYNC_EN.

Test Plan:
- 8N1, wls=11, pen=0, send 8'hA5 -> one push, dout=A5, pe=fe=bi=0, rx_busy low afterwards.
- 7E1, wls=10, pen=1, eps=1, send 7'h41 with correct parity bit 0 -> dout=8'h41, pe=0; repeat with parity bit 1 -> pe=1.
- 5-bit, stick parity, {sticky_parity,eps}=10, send 5'h1F with parity bit 0 -> dout=8'h1F, pe=1.
- Glitch: rx low for 4 baud_pulses then high -> no push, state back to IDLE.
- Break: rx held low for 3 frame times, 8N1 -> exactly one push with dout=00, fe=1, bi=1; no further push until rx high, then next frame 8'h3C is received correctly.
- rst_n asserted mid-DATA -> outputs reset immediately, no push; the following frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types, defaults, word-length decode and parity helper.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int MID_SAMPLE_DEF = OVERSAMPLE_DEF / 2 - 1;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_rx_state_t;

    // Index of the last data bit for a given word-length select.
    function automatic logic [2:0] wls_last_idx(input logic [1:0] wls);
        case (wls)
            WLS_5:   return 3'd4;
            WLS_6:   return 3'd5;
            WLS_7:   return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    // Unused upper data bits are zero, so reducing over all 8 bits is exact.
    function automatic logic parity_expected(input logic [7:0] data,
                                             input logic       sticky,
                                             input logic       eps);
        case ({sticky, eps})
            2'b00:   return ~^data;
            2'b01:   return ^data;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_sync
// Brief  : Two-flop synchronizer for the serial input, resets to idle-high.
// Rev    : 1.0
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_top.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_top
// Brief  : 16550-style UART receiver with parity, framing and break detect.
//          Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on rx.
// Rev    : 1.0
// ============================================================================
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int MID_SAMPLE = OVERSAMPLE / 2 - 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       sticky_parity,
    input  logic       eps,
    input  logic       pen,
    input  logic [1:0] wls,
    output logic       push,
    output logic [7:0] dout,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       rx_busy
);

    localparam int             CW         = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  c_CNT_BIT  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]  c_CNT_MID  = CW'(MID_SAMPLE);

    logic w_rx;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx)
    );
`else
    assign w_rx = rx;
`endif

    uart_rx_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]     r_idx, w_idx_nxt;
    logic [7:0]     r_data, w_data_nxt;
    logic           r_par, w_par_nxt;
    logic [1:0]     r_wls;
    logic           r_pen, r_eps, r_stick;
    logic           w_cfg_ld;
    logic           w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_par   <= 1'b0;
            r_wls   <= '0;
            r_pen   <= 1'b0;
            r_eps   <= 1'b0;
            r_stick <= 1'b0;
            push    <= 1'b0;
            dout    <= '0;
            pe      <= 1'b0;
            fe      <= 1'b0;
            bi      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_par   <= w_par_nxt;
            push    <= w_push;
            if (w_cfg_ld) begin
                r_wls   <= wls;
                r_pen   <= pen;
                r_eps   <= eps;
                r_stick <= sticky_parity;
            end
            if (w_push) begin
                dout <= r_data;
                pe   <= r_pen & (r_par != parity_expected(r_data, r_stick, r_eps));
                fe   <= ~w_rx;
                bi   <= (r_data == 8'h00) & (~r_pen | ~r_par) & ~w_rx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_par_nxt   = r_par;
        w_cfg_ld    = 1'b0;
        w_push      = 1'b0;
        if (baud_pulse) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = c_CNT_MID;
                        w_cfg_ld    = 1'b1;
                        w_data_nxt  = '0;
                        w_idx_nxt   = '0;
                        w_par_nxt   = 1'b0;
                    end
                end
                START: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else if (!w_rx) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = c_CNT_BIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                DATA: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_data_nxt[r_idx] = w_rx;
                        w_cnt_nxt         = c_CNT_BIT;
                        if (r_idx == wls_last_idx(r_wls)) begin
                            w_state_nxt = r_pen ? PARITY : STOP;
                        end else begin
                            w_idx_nxt = r_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_par_nxt   = w_rx;
                        w_cnt_nxt   = c_CNT_BIT;
                        w_state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = w_rx ? IDLE : BREAK_WAIT;
                    end
                end
                // A held-low line must return high before a new start can be seen.
                BREAK_WAIT: begin
                    if (w_rx) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign rx_busy = (r_state != IDLE);

endmodule : uart_rx_top
`default_nettype wire

// File: tb/tb_uart_rx_top.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_top
// Brief  : Directed self-checking bench for uart_rx_top.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_top;

    logic       clk;
    logic       rst_n;
    logic       baud_pulse;
    logic       rx;
    logic       sticky_parity;
    logic       eps;
    logic       pen;
    logic [1:0] wls;
    logic       push;
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       rx_busy;

    logic [1:0] r_div;
    int         n_push;
    int         n_pass;
    int         n_total;
    int         p0;

    uart_rx_top dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_pulse    (baud_pulse),
        .rx            (rx),
        .sticky_parity (sticky_parity),
        .eps           (eps),
        .pen           (pen),
        .wls           (wls),
        .push          (push),
        .dout          (dout),
        .pe            (pe),
        .fe            (fe),
        .bi            (bi),
        .rx_busy       (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        r_div      = 2'd0;
        baud_pulse = 1'b0;
    end

    always @(posedge clk) begin
        r_div      <= r_div + 2'd1;
        baud_pulse <= (r_div == 2'd3);
    end

    initial n_push = 0;
    always @(negedge clk) begin
        if (push === 1'b1) n_push++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Returns #1 after the clock edge that consumed the n-th baud pulse.
    task automatic wait_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (baud_pulse !== 1'b1) @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input bit has_par,
                              input bit par, input bit stop);
        rx = 1'b0;
        wait_pulses(16);
        for (int i = 0; i < n; i++) begin
            rx = d[i];
            wait_pulses(16);
        end
        if (has_par) begin
            rx = par;
            wait_pulses(16);
        end
        rx = stop;
        wait_pulses(16);
        if (stop) wait_pulses(16);
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        rx            = 1'b1;
        sticky_parity = 1'b0;
        eps           = 1'b0;
        pen           = 1'b0;
        wls           = 2'b11;
        #23;
        check("rst_push",   {31'd0, push},    32'd0);
        check("rst_dout",   {24'd0, dout},    32'h00);
        check("rst_pe",     {31'd0, pe},      32'd0);
        check("rst_fe",     {31'd0, fe},      32'd0);
        check("rst_bi",     {31'd0, bi},      32'd0);
        check("rst_busy",   {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        wait_pulses(4);

        // 8N1 0xA5
        p0 = n_push;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        check("a5_npush", n_push - p0,      32'd1);
        check("a5_dout",  {24'd0, dout},    32'hA5);
        check("a5_pe",    {31'd0, pe},      32'd0);
        check("a5_fe",    {31'd0, fe},      32'd0);
        check("a5_bi",    {31'd0, bi},      32'd0);
        check("a5_busy",  {31'd0, rx_busy}, 32'd0);

        // 7E1 0x41: even parity, correct bit is 0
        wls = 2'b10; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
        check("7e1_dout", {24'd0, dout}, 32'h41);
        check("7e1_pe0",  {31'd0, pe},   32'd0);
        p0 = n_push;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        check("7e1_npush", n_push - p0,  32'd1);
        check("7e1_pe1",  {31'd0, pe},   32'd1);

        // 5-bit, stick parity expecting 1, sent 0
        wls = 2'b00; pen = 1'b1; eps = 1'b0; sticky_parity = 1'b1;
        send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
        check("stk_dout", {24'd0, dout}, 32'h1F);
        check("stk_pe",   {31'd0, pe},   32'd1);
        check("stk_fe",   {31'd0, fe},   32'd0);

        // Glitch shorter than half a bit
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
        p0 = n_push;
        rx = 1'b0;
        wait_pulses(4);
        rx = 1'b1;
        wait_pulses(16);
        check("glt_npush", n_push - p0,      32'd0);
        check("glt_busy",  {31'd0, rx_busy}, 32'd0);

        // Framing error on non-zero data: fe without bi
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0);
        check("fe_dout", {24'd0, dout},    32'h81);
        check("fe_fe",   {31'd0, fe},      32'd1);
        check("fe_bi",   {31'd0, bi},      32'd0);
        check("fe_busy", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        wait_pulses(16);
        check("fe_idle", {31'd0, rx_busy}, 32'd0);

        // Break: line low for three 8N1 frame times
        p0 = n_push;
        rx = 1'b0;
        wait_pulses(480);
        check("brk_npush", n_push - p0,      32'd1);
        check("brk_dout",  {24'd0, dout},    32'h00);
        check("brk_fe",    {31'd0, fe},      32'd1);
        check("brk_bi",    {31'd0, bi},      32'd1);
        check("brk_busy",  {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        wait_pulses(32);
        check("brk_npush2", n_push - p0,      32'd1);
        check("brk_idle",   {31'd0, rx_busy}, 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        check("3c_npush", n_push - p0,   32'd2);
        check("3c_dout",  {24'd0, dout}, 32'h3C);
        check("3c_fe",    {31'd0, fe},   32'd0);
        check("3c_bi",    {31'd0, bi},   32'd0);

        // Reset in the middle of the data bits
        p0 = n_push;
        rx = 1'b0;
        wait_pulses(16);
        rx = 1'b1;
        wait_pulses(16 * 3 + 5);
        check("mid_busy_pre", {31'd0, rx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout", {24'd0, dout},    32'h00);
        check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("mid_rst_push", {31'd0, push},    32'd0);
        #2;
        rst_n = 1'b1;
        wait_pulses(16);
        check("mid_npush", n_push - p0, 32'd0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        check("5a_npush", n_push - p0,   32'd1);
        check("5a_dout",  {24'd0, dout}, 32'h5A);
        check("5a_pe",    {31'd0, pe},   32'd0);
        check("5a_fe",    {31'd0, fe},   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_rx_top
`default_nettype wire
